mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port program/data memory between two bus masters: req 0 = cpu core, req 1 = loader/DMA.
//  Serialises accesses with round-robin fairness and optional locked bursts. Drives the memory-side addr/wdata/wr_en.
//  Separate rdata/wdata buses; no tristates. Sits between the masters and the memory model in the top level.
// PARAMETERS
//  WORD_SIZE  16  data width (default from `WORD_SIZE)
//  ADDR_SIZE  8   address width (default from `ADDR_SIZE)
//  MEM_LAT    1   memory read latency in cycles after ISSUE; legal 1..7
//  MAX_BURST  4   max consecutive locked grants to one master; legal 1..15
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          synchronous reset, active-high
//  req0/req1  in   1          access request, master 0/1
//  we0/we1    in   1          1 = write, 0 = read
//  lock0/lock1 in  1          request to keep ownership for the next access
//  addr0/addr1 in  ADDR_SIZE  access address
//  wdata0/wdata1 in WORD_SIZE write data
//  gnt0/gnt1  out  1          master owns memory (ISSUE..DONE)
//  ack0/ack1  out  1          1-cycle pulse: access complete, rdata valid on reads
//  rdata      out  WORD_SIZE  read data, held until next ack
//  mem_addr   out  ADDR_SIZE  memory address
//  mem_wdata  out  WORD_SIZE  memory write data
//  mem_wr_en  out  1          memory write strobe, exactly 1 cycle per write
//  mem_rdata  in   WORD_SIZE  memory read data
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE; gnt*, ack*, mem_wr_en = 0; rdata, mem_addr, mem_wdata = 0;
//    last_owner=1, so master 0 wins the first tie; burst_cnt=0; lock_q=0.
//  - FSM: IDLE(0) -> ISSUE(1) -> WAIT(2) x MEM_LAT -> DONE(3) -> IDLE. Encodings fixed as listed.
//  - IDLE: if any req, pick owner; latch we/addr/wdata/lock of the owner; -> ISSUE. No req: stay.
//  - Pick rule, in order:
//    (a) lock_q && req[last_owner] && burst_cnt<MAX_BURST-1: same owner, burst_cnt++.
//    (b) both req: owner = ~last_owner.
//    (c) single req: that master.
//    On (b)/(c), burst_cnt=0.
//  - ISSUE: 1 cycle. mem_addr=addr_q, mem_wdata=wdata_q, mem_wr_en=we_q. gnt[owner]=1 from ISSUE through DONE.
//  - WAIT: down-counter loaded with MEM_LAT-1; on its last cycle rdata <= mem_rdata (reads only; writes keep rdata).
//  - DONE: ack[owner]=1 for 1 cycle; gnt drops on exit; last_owner <= owner; -> IDLE.
//  - Latency: req seen in IDLE -> ack after MEM_LAT+2 cycles. Min IDLE gap of 1 cycle between accesses.
//  - Masters hold req until ack. A req still high in the IDLE after DONE is a new access.
//    Dropping req before ack does not abort; ack still pulses.
//  - Inputs of a non-owner are ignored while busy. gnt0&gnt1 and ack0&ack1 never both 1.
//  - Lock honoured only if the owner re-requests in the following IDLE; otherwise lock_q is cleared.
//  - Reset mid-access: next edge returns to IDLE, mem_wr_en=0, no ack issued.
// STRUCTURE
//  - State encodings ARB_IDLE..ARB_DONE and MEM_LAT/MAX_BURST defaults go in macros/top_macro.vh.
//  - One sub-module: rr_pick2 (combinational 2-way picker: req[1:0], last_owner, lock/burst in -> owner, burst_cnt_clr out).
//  - Counters: lat_cnt 3 bits, burst_cnt 4 bits.
// TESTING
//  1. rst high 2 cycles, then release -> all outputs 0, state IDLE, no mem_wr_en glitch.
//  2. req0 read addr 0x10, mem returns 0xBEEF -> gnt0 at ISSUE, ack0 at cycle 3 (MEM_LAT=1), rdata=0xBEEF.
//  3. req0+req1 writes same cycle after reset -> master 0 first, then master 1; exactly 2 mem_wr_en pulses, addrs in order.
//  4. Both hold req continuously, lock=0 -> grants alternate 0,1,0,1; no ack overlap.
//  5. req1+lock1 held, req0 held, MAX_BURST=4 -> 4 consecutive master 1 grants, then master 0.
//  6. rst asserted during WAIT of a read -> no ack, gnt=0 next cycle, next req served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Purpose : shared types, widths and defaults for the two-master memory arbiter.
// Contents: arbiter state encoding, counter widths, parameter defaults and a
//           helper that turns an owner index into a one-hot master vector.
package mem_arbiter_pkg;

    localparam int unsigned WORD_SIZE_DEF = 16;
    localparam int unsigned ADDR_SIZE_DEF = 8;
    localparam int unsigned MEM_LAT_DEF   = 1;
    localparam int unsigned MAX_BURST_DEF = 4;

    localparam int unsigned LAT_CNT_W   = 3;
    localparam int unsigned BURST_CNT_W = 4;

    // Encodings are fixed; other blocks decode them.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // Owner index to {master1, master0} strobe vector.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose : bundle of master-side and memory-side signals of the arbiter.
// Modports: master - both bus masters (drive req/we/lock/addr/wdata, see gnt/ack/rdata)
//           slave  - the arbiter itself
//           mem    - the single-port memory (sees addr/wdata/wr_en, returns rdata)
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 8
);
    logic                 req0, req1;
    logic                 we0, we1;
    logic                 lock0, lock1;
    logic [ADDR_SIZE-1:0] addr0, addr1;
    logic [WORD_SIZE-1:0] wdata0, wdata1;
    logic                 gnt0, gnt1;
    logic                 ack0, ack1;
    logic [WORD_SIZE-1:0] rdata;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_wr_en;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, ack0, ack1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, ack0, ack1, rdata,
        output mem_addr, mem_wdata, mem_wr_en,
        input  mem_rdata
    );

    modport mem (
        input  mem_addr, mem_wdata, mem_wr_en,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Purpose : combinational two-way round-robin picker with locked-burst hold.
// Ports   : i_req[1:0]      pending requests {master1, master0}
//           i_last_owner    master that completed the previous access
//           i_lock_q        previous owner asked to keep ownership
//           i_burst_cnt     locked re-grants already given to i_last_owner
//           o_valid_c       at least one request present
//           o_owner_c       selected master
//           o_burst_cnt_clr_c  1 = fresh arbitration (restart burst count),
//                              0 = locked re-grant (increment burst count)
module rr_pick2
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic [1:0]             i_req,
    input  logic                   i_last_owner,
    input  logic                   i_lock_q,
    input  logic [BURST_CNT_W-1:0] i_burst_cnt,
    output logic                   o_valid_c,
    output logic                   o_owner_c,
    output logic                   o_burst_cnt_clr_c
);

    logic w_keep;

    always_comb begin
        w_keep            = i_lock_q && i_req[i_last_owner]
                            && (i_burst_cnt < BURST_CNT_W'(MAX_BURST - 1));
        o_valid_c         = |i_req;
        o_owner_c         = i_last_owner;
        o_burst_cnt_clr_c = 1'b1;
        if (w_keep) begin
            o_burst_cnt_clr_c = 1'b0;
        end else if (&i_req) begin
            // Contention: the master that did not go last wins.
            o_owner_c = ~i_last_owner;
        end else begin
            o_owner_c = i_req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one single-port memory between the cpu core (master 0) and the
//           loader/DMA (master 1). Serialises accesses IDLE->ISSUE->WAIT->DONE with
//           round-robin fairness and optional locked bursts. All outputs registered.
// Ports   : clk        system clock, rising edge
//           rst        synchronous reset, active high
//           bus        arbiter view of mem_arbiter_if: master requests in,
//                      gnt/ack/rdata out, memory addr/wdata/wr_en out, mem_rdata in
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int unsigned MEM_LAT   = MEM_LAT_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t             r_state,       w_state_nxt;
    logic                   r_owner,       w_owner_nxt;
    logic                   r_we,          w_we_nxt;
    logic                   r_lock_q,      w_lock_q_nxt;
    logic                   r_last_owner,  w_last_owner_nxt;
    logic [BURST_CNT_W-1:0] r_burst_cnt,   w_burst_cnt_nxt;
    logic [LAT_CNT_W-1:0]   r_lat_cnt,     w_lat_cnt_nxt;
    logic [1:0]             r_gnt,         w_gnt_nxt;
    logic [1:0]             r_ack,         w_ack_nxt;
    logic [WORD_SIZE-1:0]   r_rdata,       w_rdata_nxt;
    logic [ADDR_SIZE-1:0]   r_mem_addr,    w_mem_addr_nxt;
    logic [WORD_SIZE-1:0]   r_mem_wdata,   w_mem_wdata_nxt;
    logic                   r_mem_wr_en,   w_mem_wr_en_nxt;

    logic                   w_pick_valid;
    logic                   w_pick_owner;
    logic                   w_pick_clr;

    rr_pick2 #(
        .MAX_BURST(MAX_BURST)
    ) u_pick (
        .i_req            ({bus.req1, bus.req0}),
        .i_last_owner     (r_last_owner),
        .i_lock_q         (r_lock_q),
        .i_burst_cnt      (r_burst_cnt),
        .o_valid_c        (w_pick_valid),
        .o_owner_c        (w_pick_owner),
        .o_burst_cnt_clr_c(w_pick_clr)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_lock_q     <= 1'b0;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= '0;
            r_lat_cnt    <= '0;
            r_gnt        <= 2'b00;
            r_ack        <= 2'b00;
            r_rdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wr_en  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_we         <= w_we_nxt;
            r_lock_q     <= w_lock_q_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_gnt        <= w_gnt_nxt;
            r_ack        <= w_ack_nxt;
            r_rdata      <= w_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wr_en  <= w_mem_wr_en_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_we_nxt         = r_we;
        w_lock_q_nxt     = r_lock_q;
        w_last_owner_nxt = r_last_owner;
        w_burst_cnt_nxt  = r_burst_cnt;
        w_lat_cnt_nxt    = r_lat_cnt;
        w_gnt_nxt        = r_gnt;
        w_ack_nxt        = 2'b00;
        w_rdata_nxt      = r_rdata;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_wr_en_nxt  = 1'b0;

        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    // Latch the winner's request straight into the memory-side registers.
                    w_owner_nxt     = w_pick_owner;
                    w_we_nxt        = w_pick_owner ? bus.we1    : bus.we0;
                    w_lock_q_nxt    = w_pick_owner ? bus.lock1  : bus.lock0;
                    w_mem_addr_nxt  = w_pick_owner ? bus.addr1  : bus.addr0;
                    w_mem_wdata_nxt = w_pick_owner ? bus.wdata1 : bus.wdata0;
                    w_mem_wr_en_nxt = w_pick_owner ? bus.we1    : bus.we0;
                    w_gnt_nxt       = owner_onehot(w_pick_owner);
                    w_burst_cnt_nxt = w_pick_clr ? '0
                                                 : r_burst_cnt + BURST_CNT_W'(1);
                    w_state_nxt     = ARB_ISSUE;
                end else begin
                    // Lock lapses when the owner does not come straight back.
                    w_lock_q_nxt = 1'b0;
                end
            end
            ARB_ISSUE: begin
                w_lat_cnt_nxt = LAT_CNT_W'(MEM_LAT - 1);
                w_state_nxt   = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (r_lat_cnt == '0) begin
                    if (!r_we) begin
                        w_rdata_nxt = bus.mem_rdata;
                    end
                    w_ack_nxt   = owner_onehot(r_owner);
                    w_state_nxt = ARB_DONE;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - LAT_CNT_W'(1);
                end
            end
            ARB_DONE: begin
                w_gnt_nxt        = 2'b00;
                w_last_owner_nxt = r_owner;
                w_state_nxt      = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign bus.gnt0      = r_gnt[0];
    assign bus.gnt1      = r_gnt[1];
    assign bus.ack0      = r_ack[0];
    assign bus.ack1      = r_ack[1];
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wr_en = r_mem_wr_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter. A timeline reference model predicts
//           every output each cycle; a vector table covers single accesses and short
//           directed sequences cover contention, alternation, bursts and reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned WS  = 16;
    localparam int unsigned AS  = 8;
    localparam int          LAT = 1;
    localparam int          MB  = 4;

    logic clk;
    logic rst;
    logic mem_load;

    mem_arbiter_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus ();

    mem_arbiter #(
        .WORD_SIZE(WS), .ADDR_SIZE(AS), .MEM_LAT(LAT), .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WS-1:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (b == 8'h10) ? 16'hBEEF : {b, ~b};
    endfunction

    // Memory behind the arbiter: combinational read, write on the strobe edge.
    logic [WS-1:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    logic [WS-1:0] ref_mem [256];
    int            cyc = 0;
    int            start_e;
    int            next_free = 0;
    bit            m_active, m_owner, m_we, m_last, m_lock;
    int            m_burst;
    logic [AS-1:0] m_addr;
    logic [WS-1:0] m_wdata;
    logic [1:0]    e_gnt, e_ack;
    logic          e_wr;
    logic [WS-1:0] e_rdata, e_mem_wdata;
    logic [AS-1:0] e_mem_addr;

    // Called with the inputs about to be sampled; predicts outputs after the edge.
    task automatic model_edge();
        bit r0, r1;
        int d;
        cyc++;
        e_ack = 2'b00;
        e_wr  = 1'b0;
        if (rst) begin
            m_active = 0; e_gnt = 2'b00; e_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
            m_last = 1; m_lock = 0; m_burst = 0; next_free = cyc + 1;
            return;
        end
        if (!m_active && cyc >= next_free) begin
            r0 = bus.req0; r1 = bus.req1;
            if (r0 || r1) begin
                if (m_lock && (m_last ? r1 : r0) && (m_burst + 1 < MB)) begin
                    m_owner = m_last;
                    m_burst++;
                end else begin
                    m_burst = 0;
                    m_owner = (r0 && r1) ? !m_last : r1;
                end
                m_last    = m_owner;
                m_we      = m_owner ? bus.we1    : bus.we0;
                m_lock    = m_owner ? bus.lock1  : bus.lock0;
                m_addr    = m_owner ? bus.addr1  : bus.addr0;
                m_wdata   = m_owner ? bus.wdata1 : bus.wdata0;
                m_active  = 1;
                start_e   = cyc;
                next_free = cyc + LAT + 3;
            end else begin
                m_lock = 0;
            end
        end
        if (m_active) begin
            d = cyc - start_e;
            if (d == 0) begin
                e_gnt = m_owner ? 2'b10 : 2'b01;
                e_wr  = m_we;
                e_mem_addr  = m_addr;
                e_mem_wdata = m_wdata;
                if (m_we) ref_mem[m_addr] = m_wdata;
            end else if (d == LAT + 1) begin
                e_ack = e_gnt;
                if (!m_we) e_rdata = ref_mem[m_addr];
            end else if (d == LAT + 2) begin
                e_gnt = 2'b00;
                m_active = 0;
            end
        end
    endtask

    // ---------------- cycle stepping with per-cycle comparison ----------------
    int            glog[$];
    logic [AS-1:0] wr_addrs[$];
    logic [1:0]    prev_gnt = 2'b00;

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("gnt",       32'({bus.gnt1, bus.gnt0}), 32'(e_gnt));
        chk("ack",       32'({bus.ack1, bus.ack0}), 32'(e_ack));
        chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(e_wr));
        chk("mem_addr",  32'(bus.mem_addr), 32'(e_mem_addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_mem_wdata));
        chk("rdata",     32'(bus.rdata), 32'(e_rdata));
        if (prev_gnt == 2'b00 && {bus.gnt1, bus.gnt0} != 2'b00) glog.push_back(bus.gnt1 ? 1 : 0);
        if (bus.mem_wr_en) wr_addrs.push_back(bus.mem_addr);
        prev_gnt = {bus.gnt1, bus.gnt0};
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input bit lock,
                         input logic [AS-1:0] a, input logic [WS-1:0] d);
        if (m) begin
            bus.req1 = req; bus.we1 = we; bus.lock1 = lock; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.lock0 = lock; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        glog.delete();
        wr_addrs.delete();
    endtask

    // Hold master m's request until its ack, bounded; reports cycles from IDLE to ack.
    task automatic serve(input bit m, output int lat, output bit ok);
        lat = 0; ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            lat++;
            if ((m ? bus.ack1 : bus.ack0) == 1'b1) ok = 1;
        end
    endtask

    function automatic int log_at(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    typedef struct {
        bit            m;
        bit            we;
        logic [AS-1:0] addr;
        logic [WS-1:0] wdata;
        logic [WS-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];
    int   exp4[4] = '{0, 1, 0, 1};
    int   exp5[5] = '{1, 1, 1, 1, 0};

    initial begin : gtimeout
        #1000000;
        $display("FAIL global_timeout: still running at %0t, required to finish", $time);
        $fatal(1);
    end

    initial begin : main
        int  lat;
        bit  ok;
        bit  pend [2];
        int  rand_acks;
        bit  d0, d1;

        vecs[0] = '{m: 1'b0, we: 1'b0, addr: 8'h10, wdata: 16'h0000, exp_rdata: 16'hBEEF};
        vecs[1] = '{m: 1'b1, we: 1'b1, addr: 8'h20, wdata: 16'h1234, exp_rdata: 16'hBEEF};
        vecs[2] = '{m: 1'b0, we: 1'b0, addr: 8'h20, wdata: 16'h0000, exp_rdata: 16'h1234};
        vecs[3] = '{m: 1'b0, we: 1'b1, addr: 8'hFF, wdata: 16'hCAFE, exp_rdata: 16'h1234};
        vecs[4] = '{m: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 16'h0000, exp_rdata: 16'hCAFE};
        vecs[5] = '{m: 1'b1, we: 1'b0, addr: 8'h00, wdata: 16'h0000, exp_rdata: 16'h00FF};
        vecs[6] = '{m: 1'b0, we: 1'b0, addr: 8'h7F, wdata: 16'h0000, exp_rdata: 16'h7F80};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        mem_load = 1'b1;
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);

        // Reset: two cycles high, then everything quiet.
        do_reset(2);
        mem_load = 1'b0;
        tick();
        chk("rst_outputs", 32'({bus.gnt1, bus.gnt0, bus.ack1, bus.ack0, bus.mem_wr_en}), 32'h0);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);

        // Single accesses from the vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].m, 1, vecs[i].we, 0, vecs[i].addr, vecs[i].wdata);
            serve(vecs[i].m, lat, ok);
            chk("vec_ack_seen", 32'(ok), 32'd1);
            chk("vec_latency", 32'(lat), 32'(LAT + 2));
            chk("vec_rdata", 32'(bus.rdata), 32'(vecs[i].exp_rdata));
            drive(vecs[i].m, 0, 0, 0, '0, '0);
            tick();
        end

        // Simultaneous writes right after reset: master 0 then master 1.
        do_reset(2);
        drive(0, 1, 1, 0, 8'h30, 16'h1111);
        drive(1, 1, 1, 0, 8'h31, 16'h2222);
        d0 = 0; d1 = 0;
        for (int k = 0; k < 40 && !(d0 && d1); k++) begin
            tick();
            if (bus.ack0) begin d0 = 1; drive(0, 0, 0, 0, '0, '0); end
            if (bus.ack1) begin d1 = 1; drive(1, 0, 0, 0, '0, '0); end
        end
        chk("t3_both_done", 32'({d1, d0}), 32'h3);
        chk("t3_grants", 32'(glog.size()), 32'd2);
        chk("t3_first", 32'(log_at(0)), 32'd0);
        chk("t3_second", 32'(log_at(1)), 32'd1);
        chk("t3_wr_pulses", 32'(wr_addrs.size()), 32'd2);
        if (wr_addrs.size() == 2) begin
            chk("t3_wr_addr0", 32'(wr_addrs[0]), 32'h30);
            chk("t3_wr_addr1", 32'(wr_addrs[1]), 32'h31);
        end

        // Both requesting continuously without lock: strict alternation.
        do_reset(2);
        drive(0, 1, 0, 0, 8'h01, '0);
        drive(1, 1, 0, 0, 8'h02, '0);
        for (int k = 0; k < 60 && glog.size() < 4; k++) tick();
        for (int i = 0; i < 4; i++) chk("t4_order", 32'(log_at(i)), 32'(exp4[i]));

        // Locked burst by master 1 while master 0 waits: 4 grants then hand-over.
        do_reset(2);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 1, 0, 1, 8'h05, '0);
        tick();
        drive(0, 1, 0, 0, 8'h06, '0);
        for (int k = 0; k < 80 && glog.size() < 5; k++) tick();
        for (int i = 0; i < 5; i++) chk("t5_order", 32'(log_at(i)), 32'(exp5[i]));

        // Reset while a read is waiting on memory: aborted silently, then served again.
        do_reset(2);
        drive(1, 0, 0, 0, '0, '0);
        drive(0, 1, 0, 0, 8'h10, '0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_gnt_after_rst", 32'({bus.gnt1, bus.gnt0}), 32'h0);
        chk("t6_ack_after_rst", 32'({bus.ack1, bus.ack0}), 32'h0);
        serve(0, lat, ok);
        chk("t6_ack_seen", 32'(ok), 32'd1);
        chk("t6_latency", 32'(lat), 32'(LAT + 2));
        chk("t6_rdata", 32'(bus.rdata), 32'hBEEF);
        drive(0, 0, 0, 0, '0, '0);

        // Random traffic against the reference model.
        do_reset(2);
        pend[0] = 0; pend[1] = 0;
        rand_acks = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                bit ackm, gntm;
                ackm = (m == 1) ? bus.ack1 : bus.ack0;
                gntm = (m == 1) ? bus.gnt1 : bus.gnt0;
                if (ackm) begin
                    pend[m] = 0;
                    rand_acks++;
                end
                if (!pend[m] && ($urandom_range(0, 2) == 0)) begin
                    pend[m] = 1;
                    drive(m[0], 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          AS'($urandom_range(0, 15)), WS'($urandom));
                end else if (!pend[m]) begin
                    drive(m[0], 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          AS'($urandom), WS'($urandom));
                end else if (gntm && !ackm) begin
                    // Owner may change or drop its request once latched.
                    drive(m[0], $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, AS'($urandom), WS'($urandom));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        chk("rand_acks_seen", 32'(rand_acks > 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
